// File: rtl/uart_tx_scheduler_if.sv
// Byte-request and serial-line bundle for uart_tx_scheduler.
// master = requester/baud side, slave = scheduler side.
interface uart_tx_scheduler_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            req0_valid;
    logic [DBIT-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [DBIT-1:0] req1_data;
    logic            req1_ready;
    logic            tx;
    logic            busy;
    logic            grant_id;
    logic            tx_done_tick;

    modport master (
        output s_tick, req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, tx, busy, grant_id, tx_done_tick
    );

    modport slave (
        input  s_tick, req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, tx, busy, grant_id, tx_done_tick
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter: arbitrates in IDLE, then
// serialises start/data(LSB first)/stop paced by the s_tick oversampling strobe.
module uart_tx_scheduler #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_scheduler_if.slave    bus
);
    localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [BW-1:0]   bit_q;
    logic [DBIT-1:0] shreg_q;
    logic            tx_q;
    logic            grant_q;
    logic            last_q;
    logic            done_q;

    logic            gnt1;
    logic            ready0;
    logic            ready1;
    logic            os_end;
    logic            sb_end;
    logic [DBIT-1:0] shreg_sh;

    // Tie goes to whoever did not own the previous frame; readies are masked during reset.
    always_comb begin
        gnt1     = bus.req1_valid && (!bus.req0_valid || !last_q);
        ready0   = !rst && (state_q == IDLE) && bus.req0_valid && !gnt1;
        ready1   = !rst && (state_q == IDLE) && gnt1;
        os_end   = bus.s_tick && (tick_q == TW'(OS - 1));
        sb_end   = bus.s_tick && (tick_q == TW'(SB_TICK - 1));
        shreg_sh = shreg_q >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ready0 || ready1) begin
                        shreg_q <= ready1 ? bus.req1_data : bus.req0_data;
                        grant_q <= ready1;
                        last_q  <= ready1;
                        tick_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (os_end) begin
                        tick_q  <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else if (bus.s_tick) begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (os_end) begin
                        tick_q <= '0;
                        if (bit_q == BW'(DBIT - 1)) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shreg_q <= shreg_sh;
                            bit_q   <= bit_q + BW'(1);
                            tx_q    <= shreg_sh[0];
                        end
                    end else if (bus.s_tick) begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                STOP: begin
                    if (sb_end) begin
                        tick_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (bus.s_tick) begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.tx           = tx_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.grant_id     = grant_q;
    assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default 8N1 instance plus a 7-bit,
// two-stop-bit instance, with s_tick every 4 clocks.
module tb_uart_tx_scheduler;
    localparam int FRAME_CYC  = ((1 + 8) * 16 + 16) * 4;
    localparam int FRAME7_CYC = ((1 + 7) * 16 + 32) * 4;

    logic clk = 1'b0;
    logic rst;
    logic tick_en;
    int   cyc = 0;
    int   done_cnt = 0;
    int   xfer_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.DBIT(8)) bus ();
    uart_tx_scheduler_if #(.DBIT(7)) bus7 ();

    uart_tx_scheduler #(.DBIT(8), .OS(16), .SB_TICK(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    uart_tx_scheduler #(.DBIT(7), .OS(16), .SB_TICK(32)) dut7 (
        .clk(clk), .rst(rst), .bus(bus7)
    );

    // Ticks are sampled on edges whose number is a multiple of 4.
    assign bus.s_tick  = tick_en && (cyc % 4 == 3);
    assign bus7.s_tick = bus.s_tick;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_done_tick) done_cnt <= done_cnt + 1;
        if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
            xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at the negedge following transfer edge e; returns in the done cycle.
    task automatic expect_frame(input logic [7:0] b, input logic gid, input int e);
        int   base;
        int   at;
        logic exp;
        base = (e / 4) * 4;
        check("grant_id", bus.grant_id, gid);
        check("busy_frame", bus.busy, 1);
        for (int k = 0; k < 10; k++) begin
            wait_until(base + 32 + 64 * k);
            exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            check($sformatf("tx_bit%0d_byte%02h", k, b), bus.tx, exp);
            if (k == 0) begin
                wait_until(base + 63);
                check("start_len", bus.tx, 0);
            end
        end
        wait_until(base + FRAME_CYC - 1);
        check("stop_len", {bus.tx, bus.tx_done_tick}, 2'b10);
        at = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.tx_done_tick) begin
                at = cyc;
                break;
            end
        end
        check("done_latency", at - base, FRAME_CYC);
        check("busy_after", bus.busy, 0);
    endtask

    initial begin
        int e;
        int base;
        int bad;
        int x0;
        int d0;
        int at;

        rst = 1'b1;
        tick_en = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
        bus7.req0_valid = 1'b0; bus7.req0_data = 7'h00;
        bus7.req1_valid = 1'b0; bus7.req1_data = 7'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_done", bus.tx_done_tick, 0);
        check("rst_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("rst_tx7", bus7.tx, 1);
        bus.req0_valid = 1'b0;
        rst = 1'b0;

        // Single frame, tick-aligned so done lands exactly FRAME_CYC later
        while (cyc % 4 != 3) @(negedge clk);
        bus.req0_data = 8'hA5; bus.req0_valid = 1'b1;
        #1 check("single_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(negedge clk);
        e = cyc;
        check("single_ready_pulse", bus.req0_ready, 0);
        bus.req0_valid = 1'b0;
        expect_frame(8'hA5, 1'b0, e);

        // Tie after reset: 0x11, 0x22, 0x33
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0_data = 8'h11; bus.req0_valid = 1'b1;
        bus.req1_data = 8'h22; bus.req1_valid = 1'b1;
        #1 check("tie1_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(negedge clk);
        e = cyc;
        check("tie1_pulse", {bus.req0_ready, bus.req1_ready}, 2'b00);
        bus.req0_data = 8'h33;
        expect_frame(8'h11, 1'b0, e);
        check("tie2_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
        @(negedge clk);
        e = cyc;
        check("tie2_pulse", {bus.req0_ready, bus.req1_ready}, 2'b00);
        bus.req1_valid = 1'b0;
        expect_frame(8'h22, 1'b1, e);
        check("tie3_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(negedge clk);
        e = cyc;
        check("tie3_pulse", {bus.req0_ready, bus.req1_ready}, 2'b00);
        bus.req0_valid = 1'b0;
        expect_frame(8'h33, 1'b0, e);

        // Valid withdrawal while busy
        @(negedge clk);
        x0 = xfer_cnt;
        bus.req0_data = 8'h96; bus.req0_valid = 1'b1;
        @(negedge clk);
        e = cyc;
        bus.req0_valid = 1'b0;
        wait_until(e + 10);
        bus.req1_data = 8'hC3; bus.req1_valid = 1'b1;
        #1 check("withdraw_no_ready", bus.req1_ready, 0);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        expect_frame(8'h96, 1'b0, e);
        repeat (300) @(negedge clk);
        check("withdraw_idle", bus.busy, 0);
        check("withdraw_xfers", xfer_cnt - x0, 1);

        // Stalled ticks
        tick_en = 1'b0;
        bus.req0_data = 8'h5A; bus.req0_valid = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.tx !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        check("stall_hold", bad, 0);
        tick_en = 1'b1;
        expect_frame(8'h5A, 1'b0, cyc);

        // Async reset during data bit 3 of 0xFF from requester 1
        @(negedge clk);
        bus.req1_data = 8'hFF; bus.req1_valid = 1'b1;
        @(negedge clk);
        e = cyc;
        bus.req1_valid = 1'b0;
        base = (e / 4) * 4;
        wait_until(base + 32 + 64 * 4);
        check("rstmid_bit3", {bus.tx, bus.busy, bus.grant_id}, 3'b111);
        d0 = done_cnt;
        bus.req1_data = 8'h3C; bus.req1_valid = 1'b1;
        #2 rst = 1'b1;
        #1 check("rstmid_async", {bus.tx, bus.busy, bus.grant_id, bus.req1_ready}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_no_done", done_cnt - d0, 0);
        #1 check("rstmid_rearb", bus.req1_ready, 1);
        @(negedge clk);
        e = cyc;
        bus.req1_valid = 1'b0;
        expect_frame(8'h3C, 1'b1, e);

        // Variant: 7 data bits, two stop bits
        @(negedge clk);
        bus7.req0_data = 7'h7F; bus7.req0_valid = 1'b1;
        #1 check("v7_ready", bus7.req0_ready, 1);
        @(negedge clk);
        e = cyc;
        bus7.req0_valid = 1'b0;
        base = (e / 4) * 4;
        wait_until(base + 63);
        check("v7_start", bus7.tx, 0);
        for (int k = 1; k <= 7; k++) begin
            wait_until(base + 32 + 64 * k);
            check($sformatf("v7_bit%0d", k - 1), bus7.tx, 1);
        end
        wait_until(base + 64 * 8 + 64);
        check("v7_stop_mid", {bus7.tx, bus7.busy, bus7.tx_done_tick}, 3'b110);
        wait_until(base + FRAME7_CYC - 1);
        check("v7_stop_len", {bus7.busy, bus7.tx_done_tick}, 2'b10);
        at = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus7.tx_done_tick) begin
                at = cyc;
                break;
            end
        end
        check("v7_done_latency", at - base, FRAME7_CYC);

        repeat (4) @(negedge clk);
        check("total_done", done_cnt, 7);
        check("total_xfers", xfer_cnt, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
